// File: rtl/spi_host_pkg.sv
// Shared constants for the Wishbone SPI host: register addresses, CSR bit positions and
// shift-engine state encodings.
package spi_host_pkg;

  localparam logic [1:0] ADDR_CSR  = 2'd0;
  localparam logic [1:0] ADDR_DATA = 2'd1;

  localparam int unsigned CSR_CS       = 0;
  localparam int unsigned CSR_BUSY     = 1;
  localparam int unsigned CSR_RXV      = 2;
  localparam int unsigned CSR_OVR      = 3;
  localparam int unsigned CSR_DIV_LSB  = 8;
  localparam int unsigned CSR_DIV_MSB  = 15;
  localparam int unsigned CSR_IRQ_EN   = 16;
  localparam int unsigned CSR_IRQ_PEND = 17;

  typedef enum logic [1:0] {
    StIdle,
    StLo,
    StHi
  } state_e;

endpackage

// File: rtl/spi_host_shift.sv
// Mode-0 SPI byte shift engine: divider counter, bit counter, FSM and shift registers.
// done pulses combinationally on the cycle whose closing edge ends the byte; rx_byte is valid then.
module spi_host_shift
  import spi_host_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic [7:0] div,
  input  logic       miso,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_byte,
  output logic       sclk,
  output logic       mosi
);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    done    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLo;
          tx_d    = tx_byte;
          mosi_d  = tx_byte[7];
          sclk_d  = 1'b0;
          cnt_d   = div;
          bit_d   = '0;
        end
      end
      StLo: begin
        if (cnt_q == 8'd0) begin
          state_d = StHi;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[6:0], miso};
          cnt_d   = div;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StHi: begin
        if (cnt_q == 8'd0) begin
          sclk_d = 1'b0;
          cnt_d  = div;
          if (bit_q != 3'd7) begin
            state_d = StLo;
            tx_d    = {tx_q[6:0], 1'b0};
            mosi_d  = tx_q[6];
            bit_d   = bit_q + 3'd1;
          end else begin
            state_d = StIdle;
            done    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy    = (state_q != StIdle);
  assign rx_byte = rx_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;

endmodule

// File: rtl/spi_host_wb.sv
// Wishbone-slave SPI host: CSR/DATA decode, flags and chip select around spi_host_shift.
// Optional completion interrupt is built when SPI_HOST_IRQ_EN is defined.
module spi_host_wb
  import spi_host_pkg::*;
#(
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] wb_addr,
  input  logic [31:0]   wb_wdata,
  output logic [31:0]   wb_rdata,
  input  logic          wb_we,
  input  logic          wb_cyc,
  output logic          wb_ack,
  output logic          spi_clk,
  output logic          spi_mosi,
  input  logic          spi_miso,
  output logic          spi_cs_n
`ifdef SPI_HOST_IRQ_EN
  ,
  output logic          irq
`endif
);

  logic       ack_q;
  logic       cs_q;
  logic [7:0] div_q;
  logic       ovr_q;
  logic       rx_valid_q;
  logic [7:0] rx_data_q;
  logic       busy, done;
  logic [7:0] rx_byte;
  logic       csr_wr, data_wr, data_rd, start;
  logic [1:0] addr;
  logic [31:0] csr_val;
  logic       unused_bits;

  assign addr    = wb_addr[1:0];
  // Side effects only on the acked cycle of an access.
  assign csr_wr  = wb_cyc & ack_q & wb_we & (addr == ADDR_CSR);
  assign data_wr = wb_cyc & ack_q & wb_we & (addr == ADDR_DATA);
  assign data_rd = wb_cyc & ack_q & ~wb_we & (addr == ADDR_DATA);
  assign start   = data_wr & ~busy;
  assign unused_bits = ^{wb_addr, wb_wdata};

  spi_host_shift u_shift (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .tx_byte (wb_wdata[7:0]),
    .div     (div_q),
    .miso    (spi_miso),
    .busy    (busy),
    .done    (done),
    .rx_byte (rx_byte),
    .sclk    (spi_clk),
    .mosi    (spi_mosi)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q      <= 1'b0;
      cs_q       <= 1'b0;
      div_q      <= '0;
      ovr_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      ack_q <= wb_cyc & ~ack_q;
      if (csr_wr && !busy) begin
        cs_q  <= wb_wdata[CSR_CS];
        div_q <= wb_wdata[CSR_DIV_MSB:CSR_DIV_LSB];
      end
      if (data_wr && busy)                ovr_q <= 1'b1;
      else if (csr_wr && wb_wdata[CSR_OVR]) ovr_q <= 1'b0;
      if (done) rx_data_q <= rx_byte;
      // Completion wins over a same-cycle DATA read.
      if (done)         rx_valid_q <= 1'b1;
      else if (data_rd) rx_valid_q <= 1'b0;
    end
  end

`ifdef SPI_HOST_IRQ_EN
  logic irq_en_q, irq_pend_q, irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q   <= 1'b0;
      irq_pend_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      if (csr_wr) irq_en_q <= wb_wdata[CSR_IRQ_EN];
      if (done) irq_pend_q <= 1'b1;
      else if (data_rd || (csr_wr && wb_wdata[CSR_IRQ_PEND])) irq_pend_q <= 1'b0;
      irq_q <= irq_pend_q & irq_en_q;
    end
  end

  assign irq = irq_q;
`endif

  always_comb begin
    csr_val                          = '0;
    csr_val[CSR_CS]                  = cs_q;
    csr_val[CSR_BUSY]                = busy;
    csr_val[CSR_RXV]                 = rx_valid_q;
    csr_val[CSR_OVR]                 = ovr_q;
    csr_val[CSR_DIV_MSB:CSR_DIV_LSB] = div_q;
`ifdef SPI_HOST_IRQ_EN
    csr_val[CSR_IRQ_EN]              = irq_en_q;
    csr_val[CSR_IRQ_PEND]            = irq_pend_q;
`endif
  end

  always_comb begin
    wb_rdata = '0;
    if (ack_q) begin
      case (addr)
        ADDR_CSR:  wb_rdata = csr_val;
        ADDR_DATA: wb_rdata = {24'h0, rx_data_q};
        default:   wb_rdata = '0;
      endcase
    end
  end

  assign wb_ack   = ack_q;
  assign spi_cs_n = ~cs_q;

endmodule

// File: tb/tb_spi_host_wb.sv
// Directed self-checking bench for spi_host_wb with a mode-0 SPI device model.
// The interrupt scenario is compiled only when SPI_HOST_IRQ_EN is defined.
module tb_spi_host_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  wb_addr;
  logic [31:0] wb_wdata;
  logic [31:0] wb_rdata;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_ack;
  logic        spi_clk, spi_mosi, spi_miso, spi_cs_n;
`ifdef SPI_HOST_IRQ_EN
  logic        irq;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  spi_host_wb #(.AW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_addr  (wb_addr),
    .wb_wdata (wb_wdata),
    .wb_rdata (wb_rdata),
    .wb_we    (wb_we),
    .wb_cyc   (wb_cyc),
    .wb_ack   (wb_ack),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs_n (spi_cs_n)
`ifdef SPI_HOST_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  always #5 clk = ~clk;

  // Device model: presents MSB first, shifts on the falling SPI clock edge.
  logic [7:0] dev_q = 8'h00;
  assign spi_miso = dev_q[7];
  always @(negedge spi_clk) dev_q = dev_q << 1;

  task automatic wb_xfer(input logic we, input logic [3:0] a, input logic [31:0] wd,
                         output logic [31:0] rd);
    int k;
    wb_cyc   = 1'b1;
    wb_we    = we;
    wb_addr  = a;
    wb_wdata = wd;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!wb_ack && k < 4);
    if (!wb_ack) begin
      n_vec++; n_fail++;
      $display("FAIL wb_ack_timeout: ack=%b required 1", wb_ack);
    end
    rd = wb_rdata;
    @(posedge clk); #1;
    wb_cyc = 1'b0;
    wb_we  = 1'b0;
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [31:0] wd);
    logic [31:0] dummy;
    wb_xfer(1'b1, a, wd, dummy);
  endtask

  task automatic wb_read(input logic [3:0] a, output logic [31:0] rd);
    wb_xfer(1'b0, a, 32'h0, rd);
  endtask

  // Watches spi_clk from the start edge (index 0); every half-period must be div+1 cycles.
  task automatic poll_xfer(input int div, input int offset, input int stop_rises,
                           output int rises, output int falls, output int first_rise,
                           output int last_fall, output int bad_hp, output logic [7:0] mosi_b);
    logic prev;
    int   last_tr;
    rises = 0; falls = 0; first_rise = -1; last_fall = -1; bad_hp = 0; mosi_b = '0;
    prev = spi_clk;
    last_tr = 0;
    for (int i = offset + 1; i < offset + 600; i++) begin
      @(posedge clk); #1;
      if (spi_clk !== prev) begin
        if (i - last_tr != div + 1) bad_hp++;
        last_tr = i;
        if (spi_clk) begin
          rises++;
          if (rises == 1) first_rise = i;
          mosi_b = {mosi_b[6:0], spi_mosi};
        end else begin
          falls++;
          last_fall = i;
        end
        prev = spi_clk;
      end
      if (stop_rises < 8 && rises == stop_rises) break;
      if (falls == 8) break;
    end
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    rst = 1'b1; wb_cyc = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_wdata = '0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    n_vec++;
    if ({spi_cs_n, spi_clk, spi_mosi} !== 3'b100) begin
      n_fail++; $display("FAIL reset_pins: cs_n/clk/mosi=%b required 100",
                         {spi_cs_n, spi_clk, spi_mosi});
    end
    n_vec++;
    if ({wb_ack, wb_rdata} !== 33'h0) begin
      n_fail++; $display("FAIL reset_bus: ack=%b rdata=%h required 0/0", wb_ack, wb_rdata);
    end
    wb_read(4'd0, rd);
    n_vec++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_csr: got %h required 0", rd); end
    wb_write(4'd2, 32'hFFFF_FFFF);
    wb_read(4'd2, rd);
    n_vec++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL addr2_read: got %h required 0", rd); end
    wb_read(4'd0, rd);
    n_vec++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL addr2_ignored: csr %h required 0", rd); end
  endtask

  task automatic test_basic;
    logic [31:0] rd;
    logic [7:0]  mb;
    int r, f, fr, lf, bad;
    wb_write(4'd0, 32'h0000_0301);
    n_vec++;
    if (spi_cs_n !== 1'b0) begin n_fail++; $display("FAIL cs_assert: cs_n=%b required 0", spi_cs_n); end
    dev_q = 8'h3C;
    wb_write(4'd1, 32'h0000_00A5);
    poll_xfer(3, 0, 8, r, f, fr, lf, bad, mb);
    n_vec++;
    if (r !== 8) begin n_fail++; $display("FAIL basic_pulses: got %0d required 8", r); end
    n_vec++;
    if (bad !== 0) begin n_fail++; $display("FAIL basic_halfper: %0d bad required 0", bad); end
    n_vec++;
    if (fr !== 4) begin n_fail++; $display("FAIL basic_first_rise: got %0d required 4", fr); end
    n_vec++;
    if (lf !== 64) begin n_fail++; $display("FAIL basic_busy_len: got %0d required 64", lf); end
    n_vec++;
    if (mb !== 8'hA5) begin n_fail++; $display("FAIL basic_mosi: got %h required a5", mb); end
    wb_read(4'd0, rd);
    n_vec++;
    if (rd !== 32'h0000_0305) begin n_fail++; $display("FAIL basic_csr_done: got %h required 00000305", rd); end
    wb_read(4'd1, rd);
    n_vec++;
    if (rd !== 32'h0000_003C) begin n_fail++; $display("FAIL basic_rx: got %h required 0000003c", rd); end
    wb_read(4'd0, rd);
    n_vec++;
    if (rd !== 32'h0000_0301) begin n_fail++; $display("FAIL basic_rxv_clr: got %h required 00000301", rd); end
  endtask

  task automatic test_div0;
    logic [31:0] rd;
    logic [7:0]  mb;
    int r, f, fr, lf, bad;
    wb_write(4'd0, 32'h0000_0001);
    dev_q = 8'h81;
    wb_write(4'd1, 32'h0000_00FF);
    poll_xfer(0, 0, 8, r, f, fr, lf, bad, mb);
    n_vec++;
    if (bad !== 0 || fr !== 1) begin
      n_fail++; $display("FAIL div0_toggle: bad=%0d first=%0d required 0/1", bad, fr);
    end
    n_vec++;
    if (lf !== 16) begin n_fail++; $display("FAIL div0_busy_len: got %0d required 16", lf); end
    n_vec++;
    if (mb !== 8'hFF) begin n_fail++; $display("FAIL div0_mosi: got %h required ff", mb); end
    wb_read(4'd1, rd);
    n_vec++;
    if (rd !== 32'h0000_0081) begin n_fail++; $display("FAIL div0_rx: got %h required 00000081", rd); end
  endtask

  task automatic test_overrun;
    logic [31:0] rd;
    logic [7:0]  mb;
    int r, f, fr, lf, bad;
    wb_write(4'd0, 32'h0000_0701);
    dev_q = 8'hC3;
    wb_write(4'd1, 32'h0000_0055);
    wb_write(4'd1, 32'h0000_0011);
    wb_read(4'd0, rd);
    n_vec++;
    if (rd !== 32'h0000_070B) begin n_fail++; $display("FAIL ovr_set: csr %h required 0000070b", rd); end
    poll_xfer(7, 4, 8, r, f, fr, lf, bad, mb);
    n_vec++;
    if (mb !== 8'h55 || lf !== 128 || bad !== 0) begin
      n_fail++; $display("FAIL ovr_byte_kept: mosi=%h end=%0d bad=%0d required 55/128/0", mb, lf, bad);
    end
    wb_read(4'd1, rd);
    n_vec++;
    if (rd !== 32'h0000_00C3) begin n_fail++; $display("FAIL ovr_rx: got %h required 000000c3", rd); end
    wb_write(4'd0, 32'h0000_0709);
    wb_read(4'd0, rd);
    n_vec++;
    if (rd !== 32'h0000_0701) begin n_fail++; $display("FAIL ovr_clear: csr %h required 00000701", rd); end
  endtask

`ifdef SPI_HOST_IRQ_EN
  task automatic test_irq;
    logic [31:0] rd;
    logic [7:0]  mb;
    int r, f, fr, lf, bad;
    wb_write(4'd0, 32'h0001_0001);
    dev_q = 8'h00;
    wb_write(4'd1, 32'h0000_0000);
    poll_xfer(0, 0, 8, r, f, fr, lf, bad, mb);
    n_vec++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early: irq=%b required 0", irq); end
    @(posedge clk); #1;
    n_vec++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: irq=%b required 1", irq); end
    wb_read(4'd0, rd);
    n_vec++;
    if (rd !== 32'h0003_0005) begin n_fail++; $display("FAIL irq_csr: got %h required 00030005", rd); end
    wb_read(4'd1, rd);
    @(posedge clk); #1;
    n_vec++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_drop: irq=%b required 0", irq); end
  endtask
`endif

  task automatic test_reset_mid;
    logic [31:0] rd;
    logic [7:0]  mb;
    int r, f, fr, lf, bad;
    wb_write(4'd0, 32'h0000_0301);
    wb_write(4'd1, 32'h0000_005A);
    poll_xfer(3, 0, 8, r, f, fr, lf, bad, mb);
    wb_write(4'd1, 32'h0000_000F);
    poll_xfer(3, 0, 4, r, f, fr, lf, bad, mb);
    n_vec++;
    if (r !== 4 || spi_clk !== 1'b1) begin
      n_fail++; $display("FAIL mid_pulse4: rises=%0d clk=%b required 4/1", r, spi_clk);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({spi_cs_n, spi_clk, spi_mosi} !== 3'b100) begin
      n_fail++; $display("FAIL mid_reset_pins: cs_n/clk/mosi=%b required 100",
                         {spi_cs_n, spi_clk, spi_mosi});
    end
`ifdef SPI_HOST_IRQ_EN
    n_vec++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_reset_irq: irq=%b required 0", irq); end
`endif
    rst = 1'b0;
    wb_read(4'd0, rd);
    n_vec++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL mid_reset_csr: got %h required 0", rd); end
    wb_read(4'd1, rd);
    n_vec++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL mid_reset_rx: got %h required 0", rd); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_div0;
    test_overrun;
`ifdef SPI_HOST_IRQ_EN
    test_irq;
`endif
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
